// File: rtl/aurora_hls_rx_fifo.sv
// First-word-fall-through receive FIFO between the Aurora RX user stream and an HLS kernel.
// Define AURORA_HLS_RX_FIFO_STATS_EN to build the overflow_count / max_fill statistics.
module aurora_hls_rx_fifo #(
    parameter int DATA_WIDTH        = 256,
    parameter int DEPTH             = 512,
    parameter int PROG_FULL_THRESH  = 384,
    parameter int PROG_EMPTY_THRESH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic                        fifo_rx_prog_full,
    output logic                        fifo_rx_prog_empty,
    output logic                        overflow,
    input  logic                        counter_reset,
    output logic [31:0]                 overflow_count,
    output logic [31:0]                 max_fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = DATA_WIDTH / 8;
    localparam int BW = DATA_WIDTH + KW + 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_L  = (AW+1)'(PROG_FULL_THRESH);
    localparam logic [AW:0] EMPTY_L = (AW+1)'(PROG_EMPTY_THRESH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aurora_hls_rx_fifo: DEPTH must be a power of two >= 4");
    end
    if (!(PROG_EMPTY_THRESH > 0 && PROG_EMPTY_THRESH < PROG_FULL_THRESH &&
          PROG_FULL_THRESH < DEPTH)) begin : g_bad_thresh
        $error("aurora_hls_rx_fifo: need 0 < PROG_EMPTY_THRESH < PROG_FULL_THRESH < DEPTH");
    end

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fill_q, fill_d;
    logic          prog_full_q, prog_empty_q;
    logic          overflow_q, overflow_d;
    logic          rd_fire, wr_fire, drop;

    // A full FIFO still accepts a beat when the kernel drains one on the same edge.
    always_comb begin
        rd_fire    = (fill_q != '0) && m_axis_tready;
        wr_fire    = s_axis_tvalid && ((fill_q != DEPTH_L) || rd_fire);
        drop       = s_axis_tvalid && !wr_fire;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        case ({wr_fire, rd_fire})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        if (counter_reset) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fill_q       <= fill_d;
            prog_full_q  <= (fill_d >= FULL_L);
            prog_empty_q <= (fill_d <= EMPTY_L);
            overflow_q   <= overflow_d;
        end
    end

    // Head entry is read combinationally so the first beat falls through.
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q];
    assign m_axis_tvalid      = (fill_q != '0);
    assign fill_level         = fill_q;
    assign fifo_rx_prog_full  = prog_full_q;
    assign fifo_rx_prog_empty = prog_empty_q;
    assign overflow           = overflow_q;

`ifdef AURORA_HLS_RX_FIFO_STATS_EN
    logic [31:0] ovf_cnt_q, ovf_cnt_d;
    logic [31:0] max_fill_q, max_fill_d;

    always_comb begin
        ovf_cnt_d  = ovf_cnt_q;
        max_fill_d = max_fill_q;
        if (counter_reset) begin
            ovf_cnt_d  = '0;
            max_fill_d = '0;
        end else begin
            if (drop && ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + 32'd1;
            end
            if (32'(fill_d) > max_fill_q) begin
                max_fill_d = 32'(fill_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q  <= '0;
            max_fill_q <= '0;
        end else begin
            ovf_cnt_q  <= ovf_cnt_d;
            max_fill_q <= max_fill_d;
        end
    end

    assign overflow_count = ovf_cnt_q;
    assign max_fill       = max_fill_q;
`else
    assign overflow_count = '0;
    assign max_fill       = '0;
`endif

endmodule

// File: tb/tb_aurora_hls_rx_fifo.sv
// Directed bench for aurora_hls_rx_fifo with a queue-based reference model checked every cycle.
module tb_aurora_hls_rx_fifo;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int PF    = 12;
    localparam int PE    = 4;
`ifdef AURORA_HLS_RX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tready;
    logic [4:0]    fill_level;
    logic          prog_full;
    logic          prog_empty;
    logic          overflow;
    logic          counter_reset;
    logic [31:0]   overflow_count;
    logic [31:0]   max_fill;

    aurora_hls_rx_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .fill_level(fill_level), .fifo_rx_prog_full(prog_full),
        .fifo_rx_prog_empty(prog_empty), .overflow(overflow),
        .counter_reset(counter_reset), .overflow_count(overflow_count), .max_fill(max_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    bit chk  = 1'b0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t       q[$];
    bit          m_ovf = 1'b0;
    int unsigned m_cnt = 0;
    int          m_max = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, rules applied at every rising edge.
    always @(posedge clk) begin : model
        bit rd, wr;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
            m_max = 0;
        end else begin
            rd = (q.size() != 0) && m_tready;
            wr = s_tvalid && ((q.size() < DEPTH) || rd);
            if (rd) void'(q.pop_front());
            if (wr) q.push_back({s_tdata, s_tkeep, s_tlast});
            if (counter_reset) begin
                m_ovf = 1'b0;
                m_cnt = 0;
                m_max = 0;
            end else begin
                if (s_tvalid && !wr) begin
                    m_ovf = 1'b1;
                    if (STATS && m_cnt != 32'hFFFF_FFFF) m_cnt++;
                end
                if (STATS && q.size() > m_max) m_max = q.size();
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("fill_level", fill_level, q.size());
            check("m_tvalid", m_tvalid, q.size() != 0);
            if (q.size() != 0) begin
                check("m_tdata", m_tdata, q[0].d);
                check("m_tkeep", m_tkeep, q[0].k);
                check("m_tlast", m_tlast, q[0].l);
            end
            check("prog_full", prog_full, q.size() >= PF);
            check("prog_empty", prog_empty, q.size() <= PE);
            check("overflow", overflow, m_ovf);
            check("overflow_count", overflow_count, m_cnt);
            check("max_fill", max_fill, m_max);
        end
    end

    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l, input bit rdy,
                       input bit cr = 1'b0);
        s_tvalid      = v;
        s_tdata       = d;
        s_tkeep       = d[KW-1:0];
        s_tlast       = l;
        m_tready      = rdy;
        counter_reset = cr;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        m_tready = 1'b0; counter_reset = 1'b0;

        // Reset held two edges with traffic present.
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
        cyc(1'b1, 32'hBEEF, 1'b1, 1'b0);
        check("rst_fill", fill_level, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_prog_empty", prog_empty, 1);
        check("rst_prog_full", prog_full, 0);
        check("rst_overflow", overflow, 0);
        chk = 1'b1;
        rst = 1'b0;

        // Latency and ordering.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, DW'(i), i == 5, 1'b0);
            if (i == 1) begin
                check("lat_tvalid", m_tvalid, 1);
                check("lat_tdata", m_tdata, 1);
            end
        end
        check("lat_fill5", fill_level, 5);
        for (int i = 1; i <= 5; i++) begin
            check("order_tdata", m_tdata, i);
            check("order_tlast", m_tlast, i == 5);
            cyc(1'b0, '0, 1'b0, 1'b1);
        end
        check("order_empty", fill_level, 0);

        // Threshold flags on the way up and down.
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 32'h100 + DW'(i), 1'b0, 1'b0);
            if (i == 4)  check("thr_pe_at4", prog_empty, 1);
            if (i == 5)  check("thr_pe_at5", prog_empty, 0);
            if (i == 11) check("thr_pf_at11", prog_full, 0);
            if (i == 12) begin
                check("thr_pf_at12", prog_full, 1);
                check("thr_fill12", fill_level, 12);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            if (i == 1) begin
                check("thr_pf_down11", prog_full, 0);
                check("thr_fill11", fill_level, 11);
            end
            if (i == 7) check("thr_pe_down5", prog_empty, 0);
            if (i == 8) begin
                check("thr_pe_down4", prog_empty, 1);
                check("thr_fill4", fill_level, 4);
            end
        end
        repeat (4) cyc(1'b0, '0, 1'b0, 1'b1);

        // Overflow: 20 writes into 16 entries.
        for (int i = 1; i <= 20; i++) cyc(1'b1, 32'h200 + DW'(i), i == 16, 1'b0);
        check("ovf_fill", fill_level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_count", overflow_count, STATS ? 4 : 0);
        check("ovf_max", max_fill, STATS ? 16 : 0);

        // counter_reset on the same edge as a dropped beat.
        cyc(1'b1, 32'h2FF, 1'b0, 1'b0, 1'b1);
        check("cr_overflow", overflow, 0);
        check("cr_count", overflow_count, 0);
        check("cr_max", max_fill, 0);
        check("cr_fill", fill_level, 16);

        // Write and read together while full.
        cyc(1'b1, 32'h300, 1'b1, 1'b1);
        check("full_rw_fill", fill_level, 16);
        check("full_rw_count", overflow_count, 0);
        check("full_rw_ovf", overflow, 0);
        for (int i = 2; i <= 16; i++) begin
            check("ovf_stored", m_tdata, 32'h200 + i);
            cyc(1'b0, '0, 1'b0, 1'b1);
        end
        check("full_rw_beat", m_tdata, 32'h300);
        check("full_rw_last", m_tlast, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("drain_fill", fill_level, 0);

        // 40-beat stream across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 32'h400 + DW'(i), i == 39, 1'b1);
            check("stream_tdata", m_tdata, 32'h400 + i);
            check("stream_fill", fill_level, 1);
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("stream_empty", fill_level, 0);

        // Reset in the middle of a burst.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + DW'(i), 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 32'h5FF, 1'b0, 1'b0);
        rst = 1'b0;
        check("midrst_fill", fill_level, 0);
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_pe", prog_empty, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("midrst_idle", fill_level, 0);
        cyc(1'b1, 32'h600, 1'b1, 1'b0);
        check("midrst_next", m_tdata, 32'h600);
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
